// File: rtl/mult_row_sequencer.sv
// mult_row_sequencer: initiator side of the row-multiplier handshake.
// Walks row_select through 0..NUM_ROWS-1, pulses begin_mult per row, captures each
// row_result into a small result file, tracks per-row overflow and keeps a running
// signed argmax. The argmax gives the classifier output of the fully-connected layer.
//
// Optional build macro MULT_SEQ_SATURATE_EN: when defined, a row that reports overflow
// is clamped to the 32-bit signed extreme indicated by row_result[31] before it is
// stored and compared. When undefined, row_result is used as-is.

module mult_row_sequencer #(
  parameter int unsigned NUM_ROWS       = 10,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [3:0]          row_select,
  output logic                begin_mult,
  input  logic                done_row,
  input  logic                w_result_ena,
  input  logic [31:0]         row_result,
  input  logic                overflow,
  output logic                busy,
  output logic                class_done,
  output logic [3:0]          class_id,
  output logic [31:0]         max_value,
  output logic [NUM_ROWS-1:0] overflow_mask,
  output logic                timeout_err,
  input  logic [3:0]          rd_index,
  output logic [31:0]         rd_data
);

  localparam int unsigned WdW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  RowLast = 4'(NUM_ROWS - 1);
  localparam logic [31:0] MinVal  = 32'h8000_0000;
  localparam logic [31:0] MaxVal  = 32'h7FFF_FFFF;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StNext,
    StFinish
  } state_e;

  state_e                state_q;
  logic [3:0]            row_q;
  logic [WdW-1:0]        wd_q;
  logic                  got_q;      // a result was captured for the current row
  logic                  begin_q;
  logic                  done_q;
  logic                  busy_q;
  logic [3:0]            id_q;
  logic [31:0]           max_q;
  logic [NUM_ROWS-1:0]   mask_q;
  logic                  terr_q;
  logic [31:0]           file_q [NUM_ROWS];

  logic [31:0]           eff_d;
  logic [NUM_ROWS-1:0]   row_hit;

  // Effective value of the incoming row result (optionally saturated on overflow).
  always_comb begin
    eff_d = row_result;
`ifdef MULT_SEQ_SATURATE_EN
    if (overflow) begin
      eff_d = row_result[31] ? MaxVal : MinVal;
    end
`endif
  end

  // One-hot decode of the current row, used to address the file and the mask.
  always_comb begin
    row_hit = '0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      row_hit[i] = (row_q == 4'(i));
    end
  end

  // Combinational read port; out-of-range indices read as zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      if (rd_index == 4'(i)) begin
        rd_data = file_q[i];
      end
    end
  end

  // Sequencer FSM with registered outputs, result file and running argmax.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      row_q   <= '0;
      wd_q    <= '0;
      got_q   <= 1'b0;
      begin_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      id_q    <= '0;
      max_q   <= '0;
      mask_q  <= '0;
      terr_q  <= 1'b0;
      for (int i = 0; i < NUM_ROWS; i++) begin
        file_q[i] <= '0;
      end
    end else begin
      // Pulse outputs default low; set only on the transition into their state.
      begin_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StIssue;
            begin_q <= 1'b1;
            busy_q  <= 1'b1;
            row_q   <= '0;
            mask_q  <= '0;
            terr_q  <= 1'b0;
            max_q   <= MinVal;
            id_q    <= '0;
          end
        end

        StIssue: begin
          state_q <= StWait;
          wd_q    <= '0;
          got_q   <= 1'b0;
        end

        StWait: begin
          wd_q <= wd_q + WdW'(1);
          if (w_result_ena) begin
            got_q <= 1'b1;
            for (int i = 0; i < NUM_ROWS; i++) begin
              if (row_hit[i]) begin
                file_q[i] <= eff_d;
                mask_q[i] <= overflow;
              end
            end
            // Strict compare: on a tie the earlier (lower) row keeps the win.
            if ($signed(eff_d) > $signed(max_q)) begin
              max_q <= eff_d;
              id_q  <= row_q;
            end
          end
          if (done_row) begin
            // Row finished without ever presenting a result: store zero, no compare.
            if (!w_result_ena && !got_q) begin
              for (int i = 0; i < NUM_ROWS; i++) begin
                if (row_hit[i]) begin
                  file_q[i] <= '0;
                end
              end
            end
            state_q <= StNext;
          end else if (wd_q == WdLast) begin
            terr_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end

        StNext: begin
          if (row_q == RowLast) begin
            state_q <= StFinish;
            done_q  <= 1'b1;
          end else begin
            row_q   <= row_q + 4'd1;
            state_q <= StIssue;
            begin_q <= 1'b1;
          end
        end

        StFinish: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign row_select    = row_q;
  assign begin_mult    = begin_q;
  assign busy          = busy_q;
  assign class_done    = done_q;
  assign class_id      = id_q;
  assign max_value     = max_q;
  assign overflow_mask = mask_q;
  assign timeout_err   = terr_q;

endmodule

// File: tb/tb_mult_row_sequencer.sv
// Scoreboard bench for mult_row_sequencer: a responder plays the row multiplier, the
// stimulus computes expected classifier results from the row values and queues them,
// and a monitor checks each class_done against the queue head.

module tb_mult_row_sequencer;

  localparam int unsigned NR = 10;
  localparam int unsigned TO = 1023;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [3:0]    row_select;
  logic          begin_mult;
  logic          done_row = 1'b0;
  logic          w_result_ena = 1'b0;
  logic [31:0]   row_result = '0;
  logic          overflow = 1'b0;
  logic          busy;
  logic          class_done;
  logic [3:0]    class_id;
  logic [31:0]   max_value;
  logic [NR-1:0] overflow_mask;
  logic          timeout_err;
  logic [3:0]    rd_index = '0;
  logic [31:0]   rd_data;

  mult_row_sequencer #(.NUM_ROWS(NR), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .row_select(row_select), .begin_mult(begin_mult),
    .done_row(done_row), .w_result_ena(w_result_ena), .row_result(row_result),
    .overflow(overflow), .busy(busy), .class_done(class_done), .class_id(class_id),
    .max_value(max_value), .overflow_mask(overflow_mask), .timeout_err(timeout_err),
    .rd_index(rd_index), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]        id;
    logic [31:0]       maxv;
    logic [15:0]       mask;
    logic [15:0][31:0] file;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] vals [16];
  logic        ovfs [16];
  logic        novals [16];
  int          lats [16];
  int          hang_row = -1;
  int          exp_row = 0;
  int          bm_total = 0;
  int          done_cyc = 0;
  int          hang_cyc = 0;
  bit          sweep_zero_req = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected classification straight from the row values.
  function automatic exp_t model();
    exp_t        e;
    logic [31:0] v;
    e.id = '0; e.maxv = 32'h8000_0000; e.mask = '0; e.file = '0;
    for (int r = 0; r < NR; r++) begin
      if (novals[r]) continue;
      v = vals[r];
`ifdef MULT_SEQ_SATURATE_EN
      if (ovfs[r]) v = vals[r][31] ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
      e.file[r] = v;
      e.mask[r] = ovfs[r];
      if ($signed(v) > $signed(e.maxv)) begin
        e.maxv = v;
        e.id   = r[3:0];
      end
    end
    return e;
  endfunction

  task automatic sweep(input logic [15:0][31:0] f);
    for (int i = 0; i < 16; i++) begin
      rd_index = i[3:0];
      #1;
      chk($sformatf("rd_data[%0d]", i), rd_data, (i < NR) ? f[i] : 32'h0);
    end
  endtask

  // Multiplier model: answers each begin_mult after lats[row] cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && begin_mult) begin
        int r;
        r = int'(row_select);
        bm_total++;
        chk("row_select", {28'h0, row_select}, exp_row);
        if (exp_row > 0) chk("issue_gap", cyc - done_cyc, 2);
        exp_row++;
        if (r == hang_row) begin
          hang_cyc = cyc;
        end else begin
          repeat (lats[r] - 1) @(negedge clk);
          w_result_ena = !novals[r];
          done_row     = 1'b1;
          row_result   = vals[r];
          overflow     = ovfs[r];
          done_cyc     = cyc;
          @(negedge clk);
          w_result_ena = 1'b0;
          done_row     = 1'b0;
          row_result   = '0;
          overflow     = 1'b0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on each class_done.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && class_done) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL class_done: got pulse expected none");
        end else begin
          e = exp_q.pop_front();
          chk("class_id", {28'h0, class_id}, {28'h0, e.id});
          chk("max_value", max_value, e.maxv);
          chk("overflow_mask", {22'h0, overflow_mask}, {16'h0, e.mask});
          chk("busy_at_done", {31'h0, busy}, 1);
          chk("done_latency", cyc - done_cyc, 2);
          sweep(e.file);
        end
      end else if (!rst && sweep_zero_req) begin
        sweep('0);
        sweep_zero_req = 1'b0;
      end
    end
  end

  task automatic clear_rows();
    for (int r = 0; r < 16; r++) begin
      vals[r] = '0; ovfs[r] = 1'b0; novals[r] = 1'b0; lats[r] = 3;
    end
    hang_row = -1;
  endtask

  task automatic set_nominal();
    int nom [10] = '{5, -2, 40, 7, 40, 0, -9, 1, 39, 3};
    clear_rows();
    for (int r = 0; r < NR; r++) vals[r] = nom[r];
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'h0, busy}, 0);
  endtask

  task automatic wait_row_begun(input int k);
    int n = 0;
    while (exp_row < k && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("row_reached", {31'h0, (exp_row >= k)}, 1);
  endtask

  task automatic run_full();
    exp_q.push_back(model());
    exp_row = 0;
    pulse_start();
    chk("busy_after_start", {31'h0, busy}, 1);
    chk("terr_cleared", {31'h0, timeout_err}, 0);
    wait_idle("run_completes", 2000);
    repeat (12) @(negedge clk);
  endtask

  initial begin
    int bm0;
    int n;
    clear_rows();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset then idle.
    bm0 = bm_total;
    repeat (50) @(negedge clk);
    chk("idle_begins", bm_total - bm0, 0);
    chk("idle_busy", {31'h0, busy}, 0);
    chk("idle_class_id", {28'h0, class_id}, 0);
    chk("idle_max", max_value, 0);
    chk("idle_mask", {22'h0, overflow_mask}, 0);
    chk("idle_terr", {31'h0, timeout_err}, 0);
    chk("idle_row_select", {28'h0, row_select}, 0);
    sweep_zero_req = 1'b1;
    repeat (20) @(negedge clk);

    // Nominal run, tie on 40 keeps row 2.
    set_nominal();
    run_full();

    // All negative.
    clear_rows();
    for (int r = 0; r < NR; r++) vals[r] = 32'(-100 + r);
    run_full();

    // Overflow on row 3.
    set_nominal();
    vals[3] = 32'h8000_0010;
    ovfs[3] = 1'b1;
    run_full();

    // Done without result on the would-be winner row: stored 0, not compared.
    set_nominal();
    vals[2]   = 1000;
    novals[2] = 1'b1;
    run_full();

    // Timeout on row 5, then a clean run.
    set_nominal();
    hang_row = 5;
    exp_row  = 0;
    bm0      = bm_total;
    pulse_start();
    n = 0;
    while (!timeout_err && n < int'(TO) + 200) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_err_set", {31'h0, timeout_err}, 1);
    chk("timeout_busy", {31'h0, busy}, 0);
    chk("timeout_latency_ok", {31'h0, (cyc - hang_cyc >= int'(TO)) && (cyc - hang_cyc <= int'(TO) + 2)}, 1);
    repeat (10) @(negedge clk);
    chk("timeout_begins", bm_total - bm0, 6);
    hang_row = -1;
    run_full();

    // Start pulses while busy are ignored.
    set_nominal();
    for (int r = 0; r < NR; r++) lats[r] = 4;
    exp_q.push_back(model());
    exp_row = 0;
    bm0     = bm_total;
    pulse_start();
    wait_row_begun(5);
    pulse_start();
    pulse_start();
    wait_idle("busy_start_completes", 2000);
    chk("busy_start_begins", bm_total - bm0, NR);
    repeat (12) @(negedge clk);

    // Reset during row 6.
    set_nominal();
    exp_row = 0;
    pulse_start();
    wait_row_begun(7);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_begin", {31'h0, begin_mult}, 0);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_class_id", {28'h0, class_id}, 0);
    chk("rst_max", max_value, 0);
    chk("rst_row_select", {28'h0, row_select}, 0);
    bm0 = bm_total;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_no_begins", bm_total - bm0, 0);
    sweep_zero_req = 1'b1;
    repeat (25) @(negedge clk);

    // Randomized runs.
    for (int k = 0; k < 6; k++) begin
      clear_rows();
      for (int r = 0; r < NR; r++) begin
        vals[r]   = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 20)) - 32'd10;
        ovfs[r]   = ($urandom_range(0, 7) == 0);
        novals[r] = ($urandom_range(0, 9) == 0);
        lats[r]   = $urandom_range(2, 6);
      end
      run_full();
    end

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timed out");
  end

endmodule
